// File: rtl/cb_wr_seq_pkg.sv
// Shared definitions for the CB port-B write sequencer and the CB write-data mapper:
// direction codes, sequencer state encoding and a small command helper.
package cb_wr_seq_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10,
    DIR_NEW  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;

  // A command with no rows or no direction completes without touching the CB.
  function automatic logic is_null_cmd(input logic [1:0] dir, input logic len_zero);
    return (dir == DIR_IDLE) || len_zero;
  endfunction

endpackage

// File: rtl/cb_wr_align.sv
// Write-alignment stage: delays the row-valid strobe by one cycle so CB_web lines up
// with the mapper's registered data, and forms the wrapped row address alongside it.
module cb_wr_align #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_vld,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [CNT_W-1:0]  i_row,
  output logic              o_web,
  output logic [ADDR_W-1:0] o_addrb
);

  logic [ADDR_W-1:0] w_row_ext;
  logic [ADDR_W-1:0] w_addr;
  logic              r_web;
  logic [ADDR_W-1:0] r_addr;

  generate
    if (CNT_W >= ADDR_W) begin : g_row_trunc
      assign w_row_ext = i_row[ADDR_W-1:0];
    end else begin : g_row_ext
      assign w_row_ext = {{(ADDR_W-CNT_W){1'b0}}, i_row};
    end
  endgenerate

  // Address arithmetic is ADDR_W wide so it wraps naturally past the top row.
  assign w_addr = i_base + w_row_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_web  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_web <= i_wr_vld;
      if (i_wr_vld) begin
        r_addr <= w_addr;
      end
    end
  end

  assign o_web   = r_web;
  assign o_addrb = r_addr;

endmodule

// File: rtl/cb_wr_seq.sv
// CB port-B write sequencer: accepts one command, steps one row per C_valid, drives the
// mapper select a cycle after each C_valid and the aligned write one cycle after that.
module cb_wr_seq
  import cb_wr_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_dir,
  input  logic [1:0]        cmd_lm_num,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic              C_valid,
  output logic [1:0]        CB_dinb_sel,
  output logic [1:0]        landmark_num_10,
  output logic              CB_web,
  output logic [ADDR_W-1:0] CB_addrb,
  output logic              busy,
  output logic              done
);

  state_e            r_state;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_dir;
  logic [1:0]        r_lm;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_row;
  logic [1:0]        r_sel;
  logic [1:0]        r_lm_out;
  logic              r_sel_vld;
  logic              r_sel_last;

  logic              w_accept;
  logic              w_take;

  assign w_accept = cmd_valid && r_ready;
  // Once every row has been counted, further C_valid pulses are ignored while the pipe drains.
  assign w_take   = (r_state == ST_RUN) && C_valid && (r_cnt != r_len);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dir      <= DIR_IDLE;
      r_lm       <= '0;
      r_base     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_row      <= '0;
      r_sel      <= SEL_NONE;
      r_lm_out   <= '0;
      r_sel_vld  <= 1'b0;
      r_sel_last <= 1'b0;
    end else begin
      r_sel      <= SEL_NONE;
      r_lm_out   <= '0;
      r_sel_vld  <= 1'b0;
      r_sel_last <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_dir   <= cmd_dir;
            r_lm    <= cmd_lm_num;
            r_base  <= cmd_base_addr;
            r_len   <= cmd_len;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (is_null_cmd(cmd_dir, cmd_len == '0)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_take) begin
            r_sel      <= r_dir;
            r_lm_out   <= r_lm;
            r_sel_vld  <= 1'b1;
            r_row      <= r_cnt;
            r_sel_last <= (r_cnt == r_len - CNT_W'(1));
            r_cnt      <= r_cnt + CNT_W'(1);
          end
          // Leave RUN once the final select is on the mapper; its write lands in FLUSH.
          if (r_sel_last) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  cb_wr_align #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_align (
    .clk      (clk),
    .rst_n    (sys_rst_n),
    .i_wr_vld (r_sel_vld),
    .i_base   (r_base),
    .i_row    (r_row),
    .o_web    (CB_web),
    .o_addrb  (CB_addrb)
  );

  assign cmd_ready       = r_ready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign CB_dinb_sel     = r_sel;
  assign landmark_num_10 = r_lm_out;

endmodule

// File: tb/tb_cb_wr_seq.sv
// Self-checking bench for cb_wr_seq: directed vector table, hand-written reset and
// busy sequences, then random traffic against a cycle-timeline reference model.
module tb_cb_wr_seq;
  import cb_wr_seq_pkg::*;

  localparam int AW = 10;
  localparam int CW = 8;
  localparam int NR = 300;
  localparam int NT = 340;
  localparam int ME = NT + 8;

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_dir;
  logic [1:0]    cmd_lm_num;
  logic [AW-1:0] cmd_base_addr;
  logic [CW-1:0] cmd_len;
  logic          C_valid;
  logic [1:0]    CB_dinb_sel;
  logic [1:0]    landmark_num_10;
  logic          CB_web;
  logic [AW-1:0] CB_addrb;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cb_wr_seq #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .sys_rst_n       (sys_rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_dir         (cmd_dir),
    .cmd_lm_num      (cmd_lm_num),
    .cmd_base_addr   (cmd_base_addr),
    .cmd_len         (cmd_len),
    .C_valid         (C_valid),
    .CB_dinb_sel     (CB_dinb_sel),
    .landmark_num_10 (landmark_num_10),
    .CB_web          (CB_web),
    .CB_addrb        (CB_addrb),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    logic [1:0]           dir;
    logic [1:0]           lm;
    logic [AW-1:0]        base;
    logic [CW-1:0]        len;
    logic [15:0]          pat;
    int                   pat_n;
    int                   exp_nwr;
    logic [3:0][AW-1:0]   exp_addr;
    int                   exp_done_off;
  } vec_t;

  vec_t tab[7];

  // random stimulus and expected timeline
  logic          rv[NT];
  logic [1:0]    rd[NT];
  logic [1:0]    rlm[NT];
  logic [AW-1:0] rb[NT];
  logic [CW-1:0] rl[NT];
  logic          rcv[NT];
  logic          e_ready[ME];
  logic          e_busy[ME];
  logic          e_done[ME];
  logic          e_web[ME];
  logic [1:0]    e_sel[ME];
  logic [1:0]    e_lm[ME];
  logic [AW-1:0] e_addr[ME];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] d, input logic [1:0] lm,
                      input logic [AW-1:0] b, input logic [CW-1:0] l, input logic cv);
    @(posedge clk);
    #1;
    cmd_valid     = v;
    cmd_dir       = d;
    cmd_lm_num    = lm;
    cmd_base_addr = b;
    cmd_len       = l;
    C_valid       = cv;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 2'b00, 2'b00, '0, '0, 1'b0);
  endtask

  function automatic vec_t mk(input logic [1:0] dir, input logic [1:0] lm,
                              input logic [AW-1:0] base, input logic [CW-1:0] len,
                              input logic [15:0] pat, input int pat_n, input int nwr,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                              input int done_off);
    vec_t r;
    r.dir          = dir;
    r.lm           = lm;
    r.base         = base;
    r.len          = len;
    r.pat          = pat;
    r.pat_n        = pat_n;
    r.exp_nwr      = nwr;
    r.exp_addr[0]  = a0;
    r.exp_addr[1]  = a1;
    r.exp_addr[2]  = a2;
    r.exp_addr[3]  = a3;
    r.exp_done_off = done_off;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int            nwr = 0;
    int            nsel = 0;
    int            ndone = 0;
    int            done_off = -1;
    int            sel_bad = 0;
    int            align_bad = 0;
    logic          prev_sel = 1'b0;
    logic          cvb;
    logic [AW-1:0] got[8];
    step(1'b1, v.dir, v.lm, v.base, v.len, 1'b0);
    check($sformatf("v%0d_accept_ready", idx), 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 30; i++) begin
      cvb = (i < v.pat_n) ? v.pat[i] : 1'b0;
      step(1'b0, 2'b00, 2'b00, '0, '0, cvb);
      if (CB_web === 1'b1) begin
        if (!prev_sel) align_bad++;
        if (nwr < 8) got[nwr] = CB_addrb;
        nwr++;
      end
      if (CB_dinb_sel !== 2'b00) begin
        nsel++;
        if (CB_dinb_sel !== v.dir || landmark_num_10 !== v.lm) sel_bad++;
      end
      prev_sel = (CB_dinb_sel !== 2'b00);
      if (done === 1'b1) begin
        ndone++;
        if (done_off < 0) done_off = i + 1;
      end
    end
    check($sformatf("v%0d_nwrites", idx), 32'(nwr), 32'(v.exp_nwr));
    check($sformatf("v%0d_nsel", idx), 32'(nsel), 32'(v.exp_nwr));
    check($sformatf("v%0d_sel_value", idx), 32'(sel_bad), 32'd0);
    check($sformatf("v%0d_web_after_sel", idx), 32'(align_bad), 32'd0);
    check($sformatf("v%0d_done_offset", idx), 32'(done_off), 32'(v.exp_done_off));
    check($sformatf("v%0d_done_count", idx), 32'(ndone), 32'd1);
    for (int k = 0; k < v.exp_nwr && k < nwr && k < 8; k++) begin
      check($sformatf("v%0d_addr%0d", idx, k), 32'(got[k]), 32'(v.exp_addr[k]));
    end
    $display("vec %0d dir=%0d lm=%0d base=0x%0h len=%0d: writes=%0d done_at=+%0d",
             idx, v.dir, v.lm, v.base, v.len, nwr, done_off);
  endtask

  // Expected timeline from the rules: the k-th counted C_valid at cycle t gives the select at
  // t+1 and the write of base+k at t+2; done follows the last such C_valid by 3 cycles.
  task automatic build_model();
    int idle_at = 0;
    int k;
    int t;
    int last;
    int dn;
    logic [AW-1:0] a;
    for (int c = 0; c < ME; c++) begin
      e_ready[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0; e_web[c] = 1'b0;
      e_sel[c] = 2'b00; e_lm[c] = 2'b00; e_addr[c] = '0;
    end
    for (int c = 0; c < NT; c++) begin
      if (c >= idle_at) begin
        e_ready[c] = 1'b1;
        if (rv[c]) begin
          $display("rnd txn @%0d dir=%0d lm=%0d base=0x%0h len=%0d", c, rd[c], rlm[c], rb[c], rl[c]);
          if (rl[c] == 0 || rd[c] == 2'b00) begin
            e_busy[c+1] = 1'b1;
            e_done[c+1] = 1'b1;
            idle_at = c + 2;
          end else begin
            k = 0;
            t = c + 1;
            last = c + 1;
            while (k < int'(rl[c]) && t < NT) begin
              if (rcv[t]) begin
                a = rb[c] + AW'(k);
                e_sel[t+1]  = rd[c];
                e_lm[t+1]   = rlm[c];
                e_web[t+2]  = 1'b1;
                e_addr[t+2] = a;
                last = t;
                k++;
              end
              t++;
            end
            dn = last + 3;
            for (int x = c + 1; x <= dn && x < ME; x++) e_busy[x] = 1'b1;
            if (dn < ME) e_done[dn] = 1'b1;
            idle_at = dn + 1;
          end
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            ready_bad;
    int            doff;
    int            nw;
    logic [AW-1:0] wa[8];
    logic          rdy_hist[12];
    logic          bsy_hist[12];

    sys_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_lm_num = 2'b00;
    cmd_base_addr = '0; cmd_len = '0; C_valid = 1'b0;

    // reset state
    #22;
    check("reset_outputs",
          32'({CB_dinb_sel, landmark_num_10, CB_web, CB_addrb, busy, done, cmd_ready}), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    idle_step();
    check("ready_after_release", 32'(cmd_ready), 32'd1);
    check("busy_after_release", 32'(busy), 32'd0);

    // directed vector table
    tab[0] = mk(DIR_POS, 2'b00, 10'd5,   8'd3, 16'h0007, 3, 3, 10'd5,   10'd6,   10'd7, 10'd0, 6);
    tab[1] = mk(DIR_NEG, 2'b00, 10'd100, 8'd2, 16'h0009, 4, 2, 10'd100, 10'd101, 10'd0, 10'd0, 7);
    tab[2] = mk(DIR_NEW, 2'b10, 10'h3FF, 8'd2, 16'h0003, 2, 2, 10'h3FF, 10'h000, 10'd0, 10'd0, 5);
    tab[3] = mk(DIR_POS, 2'b00, 10'd7,   8'd0, 16'h0007, 3, 0, 10'd0,   10'd0,   10'd0, 10'd0, 1);
    tab[4] = mk(DIR_IDLE,2'b00, 10'd7,   8'd4, 16'h000F, 4, 0, 10'd0,   10'd0,   10'd0, 10'd0, 1);
    tab[5] = mk(DIR_POS, 2'b01, 10'd0,   8'd1, 16'h0004, 3, 1, 10'd0,   10'd0,   10'd0, 10'd0, 6);
    tab[6] = mk(DIR_NEG, 2'b11, 10'h3FE, 8'd4, 16'h003F, 6, 4, 10'h3FE, 10'h3FF, 10'd0, 10'd1, 7);
    for (int i = 0; i < 7; i++) begin
      run_vec(tab[i], i);
    end

    // reset in the middle of a 4-row command, after the first row
    idle_step();
    step(1'b1, DIR_POS, 2'b00, 10'd10, 8'd4, 1'b0);
    check("rstmid_accept_ready", 32'(cmd_ready), 32'd1);
    step(1'b0, 2'b00, 2'b00, '0, '0, 1'b1);
    step(1'b0, 2'b00, 2'b00, '0, '0, 1'b1);
    check("rstmid_sel_before", 32'(CB_dinb_sel), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("rstmid_outputs_async",
          32'({CB_dinb_sel, landmark_num_10, CB_web, CB_addrb, busy, done, cmd_ready}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      C_valid = 1'b1;
      @(negedge clk);
      check($sformatf("rstmid_hold%0d", i), 32'({CB_web, busy, done}), 32'd0);
    end
    sys_rst_n = 1'b1;
    idle_step();
    check("rstmid_ready_release", 32'(cmd_ready), 32'd1);
    check("rstmid_busy_release", 32'(busy), 32'd0);
    $display("seq reset-mid-run: done");

    // cmd_valid held high during a command: next one only after done
    idle_step();
    step(1'b1, DIR_POS, 2'b00, 10'd20, 8'd2, 1'b1);
    check("busyrej_accept_ready", 32'(cmd_ready), 32'd1);
    ready_bad = 0; doff = -1; nw = 0;
    for (int i = 0; i < 12; i++) begin
      rdy_hist[i] = 1'b0;
      bsy_hist[i] = 1'b0;
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, DIR_POS, 2'b00, 10'd40, 8'd1, 1'b1);
      rdy_hist[i] = cmd_ready;
      bsy_hist[i] = busy;
      if (CB_web === 1'b1) begin
        if (nw < 8) wa[nw] = CB_addrb;
        nw++;
      end
      if (done === 1'b1 && doff < 0) doff = i;
    end
    check("busyrej_done_offset", 32'(doff), 32'd5);
    if (doff >= 1 && doff <= 9) begin
      for (int i = 1; i <= doff; i++) begin
        if (rdy_hist[i] !== 1'b0) ready_bad++;
      end
      check("busyrej_ready_low_while_busy", 32'(ready_bad), 32'd0);
      check("busyrej_ready_after_done", 32'(rdy_hist[doff+1]), 32'd1);
      check("busyrej_second_accepted", 32'(bsy_hist[doff+2]), 32'd1);
    end
    check("busyrej_nwrites", 32'(nw), 32'd3);
    if (nw >= 3) begin
      check("busyrej_addr0", 32'(wa[0]), 32'd20);
      check("busyrej_addr1", 32'(wa[1]), 32'd21);
      check("busyrej_addr2", 32'(wa[2]), 32'd40);
    end
    $display("seq busy-reject: writes=%0d done_at=+%0d", nw, doff);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 2'b00, 2'b00, '0, '0, 1'b1);
    end
    idle_step();
    idle_step();

    // random traffic against the timeline model
    for (int c = 0; c < NT; c++) begin
      if (c < NR) begin
        rv[c]  = ($urandom_range(0, 99) < 40);
        rd[c]  = 2'($urandom_range(0, 3));
        rlm[c] = 2'($urandom_range(0, 3));
        rb[c]  = AW'($urandom);
        rl[c]  = CW'($urandom_range(0, 6));
        rcv[c] = ($urandom_range(0, 99) < 60);
      end else begin
        rv[c] = 1'b0; rd[c] = 2'b00; rlm[c] = 2'b00; rb[c] = '0; rl[c] = '0; rcv[c] = 1'b1;
      end
    end
    build_model();
    for (int c = 0; c < NT; c++) begin
      step(rv[c], rd[c], rlm[c], rb[c], rl[c], rcv[c]);
      check($sformatf("rnd_ctrl_c%0d", c),
            32'({cmd_ready, busy, done, CB_web, CB_dinb_sel}),
            32'({e_ready[c], e_busy[c], e_done[c], e_web[c], e_sel[c]}));
      if (e_web[c]) begin
        check($sformatf("rnd_addr_c%0d", c), 32'(CB_addrb), 32'(e_addr[c]));
      end
      if (e_sel[c] != 2'b00) begin
        check($sformatf("rnd_lm_c%0d", c), 32'(landmark_num_10), 32'(e_lm[c]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
